// File: rtl/mips_mux_pkg.sv
// Shared types and constants for the pipelined N:1 selector and its skid buffer.
// Purely declarative: no latency or flow control lives here.
package mips_mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [63:0] ZERO_DATA = '0;

  // A 1-input mux would give $clog2 == 0; keep at least one select bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Main/skid register pair with a 3-state FSM; 1-cycle latency, strict FIFO order.
// Backpressure: o_rdy is registered from state only and drops the cycle after the skid fills.
module mux_skid_buf
  import mips_mux_pkg::*;
#(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          o_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [DW-1:0] o_dat
);

  state_t        r_state;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          w_accept;
  logic          w_pop;

  assign w_accept = i_vld && r_in_ready;
  assign w_pop    = r_out_valid && i_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main      <= i_dat;
            r_state     <= ONE;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_pop) begin
            r_main <= i_dat;
          end else if (w_accept) begin
            r_skid     <= i_dat;
            r_state    <= TWO;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        TWO: begin
          // in_ready is low here, so the only event is a pop draining the skid.
          if (w_pop) begin
            r_main     <= r_skid;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_rdy = r_in_ready;
  assign o_vld = r_out_valid;
  assign o_dat = r_main;

endmodule

// File: rtl/mux_nx1_pipe.sv
// Registered N:1 selector with out-of-range flagging and a saturating error count; 1-cycle latency.
// Backpressure: 2-entry skid absorbs a stall, in_ready is registered with no path from out_ready.
module mux_nx1_pipe
  import mips_mux_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 3,
  parameter int SEL_W     = sel_width(NUM_IN),
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] din,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        dout,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_count
);

  logic [WIDTH-1:0]     w_data;
  logic                 w_hit;
  logic                 w_accept;
  logic [WIDTH:0]       w_beat;
  logic [WIDTH:0]       w_buf_out;
  logic [ERR_CNT_W-1:0] r_err_count;

  // An index with no matching input falls through to zero data and a miss.
  always_comb begin
    w_data = ZERO_DATA[WIDTH-1:0];
    w_hit  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == k[SEL_W-1:0]) begin
        w_data = din[k*WIDTH +: WIDTH];
        w_hit  = 1'b1;
      end
    end
  end

  assign w_beat   = {~w_hit, w_data};
  assign w_accept = in_valid && in_ready;

  mux_skid_buf #(
    .DW(WIDTH + 1)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (in_valid),
    .o_rdy (in_ready),
    .i_dat (w_beat),
    .o_vld (out_valid),
    .i_rdy (out_ready),
    .o_dat (w_buf_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_accept && !w_hit && (r_err_count != {ERR_CNT_W{1'b1}})) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign dout      = w_buf_out[WIDTH-1:0];
  assign sel_err   = w_buf_out[WIDTH];
  assign err_count = r_err_count;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe: a 3x32 instance with 8-bit error counter and a 16x5 instance.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mux_nx1_pipe;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [95:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        sel_err;
  logic [7:0]  err_count;

  logic        in_valid16;
  logic        in_ready16;
  logic [3:0]  sel16;
  logic [79:0] din16;
  logic        out_valid16;
  logic        out_ready16;
  logic [4:0]  dout16;
  logic        sel_err16;
  logic [7:0]  err_count16;

  int checks = 0;
  int errors = 0;

  mux_nx1_pipe #(.WIDTH(32), .NUM_IN(3), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .sel_err(sel_err),
    .err_count(err_count)
  );

  mux_nx1_pipe #(.WIDTH(5), .NUM_IN(16), .ERR_CNT_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .sel(sel16),
    .din(din16), .out_valid(out_valid16), .out_ready(out_ready16), .dout(dout16),
    .sel_err(sel_err16), .err_count(err_count16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; sel = '0; din = '0; out_ready = 1'b0;
    in_valid16 = 1'b0; sel16 = '0; din16 = '0; out_ready16 = 1'b0;
    #23;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b want 0", sel_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    din = {32'h33, 32'h22, 32'h11};
    sel = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (dout !== 32'h22) begin errors++; $display("FAIL single_dout: got %h want 00000022", dout); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL single_sel_err: got %b want 0", sel_err); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = {32'(i*16 + 2), 32'(i*16 + 1), 32'(i*16)};
      sel = 2'(i % 3);
      in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || dout !== 32'(i*16 + i % 3)) begin
        errors++; $display("FAIL stream_beat[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, dout, 32'(i*16 + i % 3));
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; sel = 2'd0; in_valid = 1'b1;
    din = {64'h0, 32'hA0A0_0001};
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_1: got %b want 1", in_ready); end
    din = {64'h0, 32'hA0A0_0002};
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_2: got %b want 0", in_ready); end
    din = {64'h0, 32'hA0A0_0003};
    step();
    step();
    checks++; if (out_valid !== 1'b1 || dout !== 32'hA0A0_0001) begin
      errors++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=a0a00001", out_valid, dout);
    end
    out_ready = 1'b1;
    step();
    checks++; if (dout !== 32'hA0A0_0002 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second: got d=%h rdy=%b want d=a0a00002 rdy=1", dout, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || dout !== 32'hA0A0_0003) begin
      errors++; $display("FAIL bp_third: got v=%b d=%h want v=1 d=a0a00003", out_valid, dout);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra: got %b want 0", out_valid); end
  endtask

  task automatic test_out_of_range();
    out_ready = 1'b1;
    din = {32'h33, 32'h22, 32'h11};
    sel = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL oor_dout: got %h want 0", dout); end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL oor_sel_err: got %b want 1", sel_err); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL oor_count: got %0d want 1", err_count); end
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL oor_saturate: got %0d want 255", err_count); end
    sel = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (sel_err !== 1'b0 || dout !== 32'h33 || err_count !== 8'd255) begin
      errors++; $display("FAIL oor_recover: got e=%b d=%h c=%0d want e=0 d=00000033 c=255", sel_err, dout, err_count);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; sel = 2'd0; in_valid = 1'b1;
    din = {64'h0, 32'hBEEF_0001};
    step();
    din = {64'h0, 32'hBEEF_0002};
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_fill: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || dout !== 32'h0 || err_count !== 8'd0) begin
      errors++; $display("FAIL rst_mid_async: got v=%b d=%h c=%0d want v=0 d=0 c=0", out_valid, dout, err_count);
    end
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || dout !== 32'h0) begin
      errors++; $display("FAIL rst_mid_stale: got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", out_valid, in_ready, dout);
    end
  endtask

  task automatic test_sweep16();
    for (int k = 0; k < 16; k++) din16[k*5 +: 5] = 5'(31 - k);
    out_ready16 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      sel16 = 4'(k); in_valid16 = 1'b1;
      step();
      checks++; if (out_valid16 !== 1'b1 || dout16 !== 5'(31 - k) || sel_err16 !== 1'b0) begin
        errors++; $display("FAIL sweep16[%0d]: got v=%b d=%h e=%b want v=1 d=%h e=0", k, out_valid16, dout16, sel_err16, 5'(31 - k));
      end
    end
    in_valid16 = 1'b0;
    step();
    checks++; if (err_count16 !== 8'd0 || out_valid16 !== 1'b0) begin
      errors++; $display("FAIL sweep16_end: got c=%0d v=%b want c=0 v=0", err_count16, out_valid16);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_sweep16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
